// File: rtl/otsu_thresh_ctrl_pkg.sv
// Shared widths, constants, FSM encoding and small helpers for the Otsu threshold controller.
package otsu_pkg;
    localparam int N_W      = 20;
    localparam int G_W      = 23;
    localparam int VAR_W    = 54;
    localparam int CAND_W   = 8;
    localparam logic [CAND_W-1:0] NUM_CAND       = 8'd128;
    localparam logic [7:0]        THRESH_DEFAULT = 8'd64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV1 = 3'd1,
        ST_DIV2 = 3'd2,
        ST_MUL  = 3'd3,
        ST_CMP  = 3'd4
    } state_t;

    // Class means live in the 7-bit gray domain; anything larger is clamped.
    function automatic logic [6:0] sat_mean(input logic [G_W-1:0] q);
        return (|q[G_W-1:7]) ? 7'h7F : q[6:0];
    endfunction

    function automatic logic [7:0] smooth_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction
endpackage

// File: rtl/otsu_thresh_ctrl_if.sv
// Candidate-sum input bus and threshold/status outputs of the Otsu controller.
interface otsu_thresh_ctrl_if;
    import otsu_pkg::*;

    logic             dsp_vld;
    logic [N_W-1:0]   n1;
    logic [N_W-1:0]   n2;
    logic [G_W-1:0]   gray_all1;
    logic [G_W-1:0]   gray_all2;
    logic             finish_clear;
    logic             freeze;
    logic [7:0]       thresh;
    logic             thresh_vld;
    logic             busy;
    logic             err_overrun;
    logic             err_count;

    modport master (
        output dsp_vld, n1, n2, gray_all1, gray_all2, finish_clear, freeze,
        input  thresh, thresh_vld, busy, err_overrun, err_count
    );

    modport slave (
        input  dsp_vld, n1, n2, gray_all1, gray_all2, finish_clear, freeze,
        output thresh, thresh_vld, busy, err_overrun, err_count
    );
endinterface

// File: rtl/otsu_thresh_ctrl_seq_div_u.sv
// Start/done unsigned restoring divider, one quotient bit per cycle; zero divisor yields 0 in one cycle.
module seq_div_u #(
    parameter int DVD_W = 23,
    parameter int DVS_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quot
);
    localparam int CNT_W = $clog2(DVD_W);

    logic [DVD_W-1:0] r_q;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W-1:0] w_diff;
    logic             w_ge;

    assign w_shift = {r_rem, r_q[DVD_W-1]};
    assign w_diff  = w_shift[DVS_W-1:0] - r_den;
    assign w_ge    = (w_shift >= {1'b0, r_den});

    // Quotient shifts out the dividend MSB-first while the partial remainder builds up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                if (i_divisor == '0) begin
                    r_q    <= '0;
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_q    <= i_dividend;
                    r_rem  <= '0;
                    r_den  <= i_divisor;
                    r_cnt  <= CNT_W'(DVD_W - 1);
                    r_run  <= 1'b1;
                end
            end else if (r_run) begin
                if (w_ge) begin
                    r_rem <= w_diff;
                    r_q   <= {r_q[DVD_W-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[DVS_W-1:0];
                    r_q   <= {r_q[DVD_W-2:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_q;
endmodule

// File: rtl/otsu_thresh_ctrl.sv
// Otsu arg-max search over per-candidate class sums; publishes the binarisation threshold at end of frame.
// Optional OTSU_THRESH_SMOOTH_EN averages each new threshold with the previous one.
module otsu_thresh_ctrl
    import otsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    otsu_thresh_ctrl_if.slave bus
);
    state_t             r_state, w_state_nxt;
    logic               w_div_start, w_div_second, w_div_done;
    logic [G_W-1:0]     w_div_dvd, w_div_quot;
    logic [N_W-1:0]     w_div_dvs;
    logic [N_W-1:0]     r_n1, r_n2;
    logic [G_W-1:0]     r_ga2;
    logic [6:0]         r_m1, w_m, w_d;
    logic               r_mul_ph;
    logic [2*N_W-1:0]   r_nn;
    logic [13:0]        r_dd;
    logic [VAR_W-1:0]   r_var, r_best_var;
    logic [6:0]         r_best_idx;
    logic [CAND_W-1:0]  r_cand_idx;
    logic               r_fc_pend, r_busy, r_thresh_vld, r_err_overrun, r_err_count;
    logic [7:0]         r_thresh, w_thresh_new;
    logic               w_start, w_fc_any, w_apply, w_overrun;

    assign w_start   = (r_state == ST_IDLE) && bus.dsp_vld && !bus.freeze;
    assign w_overrun = (r_state != ST_IDLE) && bus.dsp_vld && !bus.freeze;
    assign w_fc_any  = r_fc_pend || (bus.finish_clear && !bus.freeze);
    // A strobe arriving with end-of-frame is evaluated first; the frame closes once back in IDLE.
    assign w_apply   = (r_state == ST_IDLE) && w_fc_any && !w_start;

    assign w_div_dvd = w_div_second ? r_ga2 : bus.gray_all1;
    assign w_div_dvs = w_div_second ? r_n2  : bus.n1;
    assign w_m       = sat_mean(w_div_quot);
    assign w_d       = (r_m1 >= w_m) ? (r_m1 - w_m) : (w_m - r_m1);

`ifdef OTSU_THRESH_SMOOTH_EN
    assign w_thresh_new = smooth_avg(r_thresh, {1'b0, r_best_idx});
`else
    assign w_thresh_new = {1'b0, r_best_idx};
`endif

    seq_div_u #(.DVD_W(G_W), .DVS_W(N_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_div_dvd),
        .i_divisor  (w_div_dvs),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and divider sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_start  = 1'b0;
        w_div_second = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_DIV1;
                    w_div_start = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DIV1: begin
                if (w_div_done) begin
                    w_state_nxt  = ST_DIV2;
                    w_div_start  = 1'b1;
                    w_div_second = 1'b1;
                end else begin
                    w_state_nxt = ST_DIV1;
                end
            end
            ST_DIV2: begin
                if (w_div_done) begin
                    w_state_nxt = ST_MUL;
                end else begin
                    w_state_nxt = ST_DIV2;
                end
            end
            ST_MUL: begin
                if (r_mul_ph) begin
                    w_state_nxt = ST_CMP;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end
            ST_CMP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, variance pipeline, arg-max tracking and end-of-frame publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n1          <= '0;
            r_n2          <= '0;
            r_ga2         <= '0;
            r_m1          <= 7'd0;
            r_mul_ph      <= 1'b0;
            r_nn          <= '0;
            r_dd          <= 14'd0;
            r_var         <= '0;
            r_best_var    <= '0;
            r_best_idx    <= 7'd0;
            r_cand_idx    <= 8'd0;
            r_fc_pend     <= 1'b0;
            r_busy        <= 1'b0;
            r_thresh      <= THRESH_DEFAULT;
            r_thresh_vld  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_count   <= 1'b0;
        end else begin
            if (w_start) begin
                r_n1  <= bus.n1;
                r_n2  <= bus.n2;
                r_ga2 <= bus.gray_all2;
            end
            if ((r_state == ST_DIV1) && w_div_done) begin
                r_m1 <= w_m;
            end
            r_mul_ph      <= (r_state == ST_MUL) && !r_mul_ph;
            r_nn          <= r_n1 * r_n2;
            r_dd          <= w_d * w_d;
            r_var         <= r_nn * r_dd;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_err_overrun <= r_err_overrun || w_overrun;
            r_thresh_vld  <= 1'b0;
            r_err_count   <= 1'b0;
            r_fc_pend     <= w_fc_any && !w_apply;
            if ((r_state == ST_CMP) && (r_cand_idx != NUM_CAND)) begin
                if ((r_cand_idx == 8'd0) || (r_var > r_best_var)) begin
                    r_best_var <= r_var;
                    r_best_idx <= r_cand_idx[6:0];
                end
                r_cand_idx <= r_cand_idx + 8'd1;
            end
            if (w_apply) begin
                if (r_cand_idx == NUM_CAND) begin
                    r_thresh     <= w_thresh_new;
                    r_thresh_vld <= 1'b1;
                end else begin
                    r_err_count  <= 1'b1;
                end
                r_cand_idx <= 8'd0;
                r_best_var <= '0;
                r_best_idx <= 7'd0;
            end
        end
    end

    assign bus.thresh      = r_thresh;
    assign bus.thresh_vld  = r_thresh_vld;
    assign bus.busy        = r_busy;
    assign bus.err_overrun = r_err_overrun;
    assign bus.err_count   = r_err_count;
endmodule

// File: tb/tb_otsu_thresh_ctrl.sv
// Directed self-checking bench for otsu_thresh_ctrl; expectations follow OTSU_THRESH_SMOOTH_EN when defined.
module tb_otsu_thresh_ctrl;
    import otsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int timeouts = 0;
    int vld_cnt = 0;
    int errc_cnt = 0;
    logic [7:0] exp_thresh = 8'd64;

    otsu_thresh_ctrl_if bus ();

    otsu_thresh_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.thresh_vld === 1'b1) vld_cnt++;
        if (bus.err_count === 1'b1) errc_cnt++;
    end

    task automatic model_publish(input logic [7:0] best);
        logic [8:0] s;
`ifdef OTSU_THRESH_SMOOTH_EN
        s = {1'b0, exp_thresh} + {1'b0, best} + 9'd1;
        exp_thresh = s[8:1];
`else
        s = {1'b0, best};
        exp_thresh = s[7:0];
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dsp_vld = 1'b0;
        bus.finish_clear = 1'b0;
        bus.freeze = 1'b0;
        bus.n1 = 20'd0;
        bus.n2 = 20'd0;
        bus.gray_all1 = 23'd0;
        bus.gray_all2 = 23'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_thresh = 8'd64;
    endtask

    // Two-gray-level histogram: class sums for candidate t.
    task automatic set_sums(input int t, input int ga, input int ca, input int gb, input int cb);
        int n1, n2, s1, s2;
        n1 = ((ga <= t) ? ca : 0) + ((gb <= t) ? cb : 0);
        s1 = ((ga <= t) ? ca * ga : 0) + ((gb <= t) ? cb * gb : 0);
        n2 = (ca + cb) - n1;
        s2 = (ca * ga + cb * gb) - s1;
        bus.n1 = 20'(n1);
        bus.n2 = 20'(n2);
        bus.gray_all1 = 23'(s1);
        bus.gray_all2 = 23'(s2);
    endtask

    task automatic pulse_cand(input int t, input int ga, input int ca, input int gb, input int cb,
                              input bit fc);
        @(posedge clk);
        #1 set_sums(t, ga, ca, gb, cb);
        bus.dsp_vld = 1'b1;
        bus.finish_clear = fc;
        @(posedge clk);
        #1 bus.dsp_vld = 1'b0;
        bus.finish_clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (bus.busy !== 1'b0) timeouts++;
    endtask

    task automatic run_frame(input int ga, input int ca, input int gb, input int cb,
                             input int first, input int last, input bit fc_last);
        for (int t = first; t <= last; t++) begin
            pulse_cand(t, ga, ca, gb, cb, fc_last && (t == last));
            wait_idle();
        end
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1 bus.finish_clear = 1'b1;
        @(posedge clk);
        #1 bus.finish_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.thresh !== 8'd64) begin errors++; $display("FAIL reset_thresh got=%0d exp=64", bus.thresh); end
        checks++; if (bus.thresh_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus.thresh_vld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", bus.err_overrun); end
        checks++; if (bus.err_count !== 1'b0) begin errors++; $display("FAIL reset_errc got=%b exp=0", bus.err_count); end
    endtask

    task automatic test_bimodal();
        int v0, e0, t0;
        do_reset();
        v0 = vld_cnt; e0 = errc_cnt; t0 = timeouts;
        run_frame(20, 512, 100, 512, 0, 127, 1'b0);
        end_frame();
        model_publish(8'd20);
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL bimodal_thresh got=%0d exp=%0d", bus.thresh, exp_thresh); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL bimodal_vld_pulses got=%0d exp=1", vld_cnt - v0); end
        checks++; if (errc_cnt - e0 !== 0) begin errors++; $display("FAIL bimodal_errc got=%0d exp=0", errc_cnt - e0); end
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL bimodal_ovr got=%b exp=0", bus.err_overrun); end
        checks++; if (timeouts - t0 !== 0) begin errors++; $display("FAIL bimodal_timeout got=%0d exp=0", timeouts - t0); end
    endtask

    task automatic test_flat();
        int v0;
        v0 = vld_cnt;
        run_frame(50, 1024, 50, 0, 0, 127, 1'b0);
        end_frame();
        model_publish(8'd0);
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL flat_thresh got=%0d exp=%0d", bus.thresh, exp_thresh); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL flat_vld_pulses got=%0d exp=1", vld_cnt - v0); end
    endtask

    task automatic test_overrun();
        int v0, e0;
        do_reset();
        v0 = vld_cnt; e0 = errc_cnt;
        pulse_cand(0, 20, 512, 100, 512, 1'b0);
        repeat (8) @(posedge clk);
        #1 checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got=%b exp=1", bus.busy); end
        pulse_cand(1, 20, 512, 100, 512, 1'b0);
        checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", bus.err_overrun); end
        wait_idle();
        // 126 more strobes: total 127 only if the dropped strobe was not counted.
        run_frame(20, 512, 100, 512, 1, 126, 1'b0);
        end_frame();
        checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.err_overrun); end
        checks++; if (errc_cnt - e0 !== 1) begin errors++; $display("FAIL ovr_cand_count_errc got=%0d exp=1", errc_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL ovr_vld got=%0d exp=0", vld_cnt - v0); end
    endtask

    task automatic test_short_frame();
        int v0, e0;
        v0 = vld_cnt; e0 = errc_cnt;
        run_frame(50, 1024, 50, 0, 0, 126, 1'b0);
        end_frame();
        checks++; if (errc_cnt - e0 !== 1) begin errors++; $display("FAIL short_errc got=%0d exp=1", errc_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL short_vld got=%0d exp=0", vld_cnt - v0); end
        checks++; if (bus.thresh !== 8'd64) begin errors++; $display("FAIL short_thresh got=%0d exp=64", bus.thresh); end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        do_reset();
        run_frame(20, 512, 100, 512, 0, 39, 1'b0);
        pulse_cand(40, 20, 512, 100, 512, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.thresh !== 8'd64) begin errors++; $display("FAIL mid_rst_thresh got=%0d exp=64", bus.thresh); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.thresh_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got=%b exp=0", bus.thresh_vld); end
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_ovr got=%b exp=0", bus.err_overrun); end
        checks++; if (bus.err_count !== 1'b0) begin errors++; $display("FAIL mid_rst_errc got=%b exp=0", bus.err_count); end
        rst = 1'b0;
        exp_thresh = 8'd64;
        v0 = vld_cnt; e0 = errc_cnt;
        run_frame(20, 512, 100, 512, 0, 127, 1'b0);
        end_frame();
        model_publish(8'd20);
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL mid_frame_thresh got=%0d exp=%0d", bus.thresh, exp_thresh); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL mid_frame_vld got=%0d exp=1", vld_cnt - v0); end
        checks++; if (errc_cnt - e0 !== 0) begin errors++; $display("FAIL mid_frame_errc got=%0d exp=0", errc_cnt - e0); end
    endtask

    task automatic test_freeze();
        int v0, e0;
        v0 = vld_cnt; e0 = errc_cnt;
        bus.freeze = 1'b1;
        pulse_cand(0, 20, 512, 100, 512, 1'b0);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL freeze_busy got=%b exp=0", bus.busy); end
        end_frame();
        checks++; if ((vld_cnt - v0) + (errc_cnt - e0) !== 0) begin errors++; $display("FAIL freeze_frame_ignored got=%0d exp=0", (vld_cnt - v0) + (errc_cnt - e0)); end
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL freeze_thresh got=%0d exp=%0d", bus.thresh, exp_thresh); end
        bus.freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        int v0, e0;
        do_reset();
        run_frame(20, 512, 100, 512, 0, 127, 1'b0);
        end_frame();
        model_publish(8'd20);
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL b2b_frame1 got=%0d exp=%0d", bus.thresh, exp_thresh); end
        v0 = vld_cnt; e0 = errc_cnt;
        // End of frame coincides with the last strobe.
        run_frame(20, 512, 100, 512, 0, 127, 1'b1);
        repeat (3) @(posedge clk);
        #1 model_publish(8'd20);
        checks++; if (bus.thresh !== exp_thresh) begin errors++; $display("FAIL b2b_frame2 got=%0d exp=%0d", bus.thresh, exp_thresh); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL b2b_vld got=%0d exp=1", vld_cnt - v0); end
        checks++; if (errc_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_errc got=%0d exp=0", errc_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_bimodal();
        test_flat();
        test_overrun();
        test_short_frame();
        test_reset_mid();
        test_freeze();
        test_back_to_back();
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL busy_timeouts got=%0d exp=0", timeouts);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
